// File: rtl/minimac2_pkg.sv
// ============================================================================
// minimac2_pkg : shared state encoding, CRC-32 constants and size defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package minimac2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DISCARD  = 2'd3
    } rx_state_e;

    localparam logic [31:0] MINIMAC2_CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] MINIMAC2_CRC_RESIDUE = 32'hDEBB20E3;
    localparam int          MINIMAC2_MAX_NIBBLES = 3072;

    localparam logic [3:0]  NIB_PRE = 4'h5;
    localparam logic [3:0]  NIB_SFD = 4'hD;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/minimac2_rx_sfd_if.sv
// ============================================================================
// minimac2_rx_sfd_if : MII receive pins in, cleaned payload stream and status out
// Optional rx_crc_ok member with MINIMAC2_RX_CRC_EN.  Rev 1.0
// ============================================================================
`default_nettype none

interface minimac2_rx_sfd_if;

    logic       mii_rx_dv;
    logic       mii_rx_er;
    logic [3:0] mii_rx_data;
    logic       phy_dv;
    logic [3:0] phy_rx_data;
    logic       rx_end;
    logic       rx_err_phy;
    logic       rx_err_align;
    logic       rx_err_long;

`ifdef MINIMAC2_RX_CRC_EN
    logic       rx_crc_ok;

    modport master (
        output mii_rx_dv, mii_rx_er, mii_rx_data,
        input  phy_dv, phy_rx_data, rx_end, rx_err_phy, rx_err_align, rx_err_long, rx_crc_ok
    );
    modport slave (
        input  mii_rx_dv, mii_rx_er, mii_rx_data,
        output phy_dv, phy_rx_data, rx_end, rx_err_phy, rx_err_align, rx_err_long, rx_crc_ok
    );
`else
    modport master (
        output mii_rx_dv, mii_rx_er, mii_rx_data,
        input  phy_dv, phy_rx_data, rx_end, rx_err_phy, rx_err_align, rx_err_long
    );
    modport slave (
        input  mii_rx_dv, mii_rx_er, mii_rx_data,
        output phy_dv, phy_rx_data, rx_end, rx_err_phy, rx_err_align, rx_err_long
    );
`endif

endinterface

`default_nettype wire

// File: rtl/minimac2_crc4.sv
// ============================================================================
// minimac2_crc4 : reflected CRC-32 register advancing 4 bits per cycle, bit 0 first
// Rev 1.0
// ============================================================================
`default_nettype none

module minimac2_crc4
    import minimac2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [3:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_REFL = reflect32(MINIMAC2_CRC_POLY);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] w_step;

    always_comb begin
        w_step = crc_q;
        for (int i = 0; i < 4; i++) begin
            if (w_step[0] ^ data_i[i]) begin
                w_step = (w_step >> 1) ^ POLY_REFL;
            end else begin
                w_step = w_step >> 1;
            end
        end
    end

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '1;
        end else if (en_i) begin
            crc_d = w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/minimac2_rx_sfd.sv
// ============================================================================
// minimac2_rx_sfd : MII preamble/SFD stripper, oversize truncation, frame status
// FCS checker enabled by MINIMAC2_RX_CRC_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module minimac2_rx_sfd
    import minimac2_pkg::*;
#(
    parameter int MIN_PREAMBLE = 4,
    parameter int MAX_NIBBLES  = MINIMAC2_MAX_NIBBLES
) (
    input  logic             phy_rx_clk,
    input  logic             phy_rx_rst,
    minimac2_rx_sfd_if.slave rx
);

    localparam logic [3:0]  PRE_MIN  = 4'(MIN_PREAMBLE);
    localparam logic [11:0] NCNT_MAX = 12'(MAX_NIBBLES);

    logic        dv_q, er_q;
    logic [3:0]  d_q;
    rx_state_e   state_q, state_d;
    logic [3:0]  pcnt_q, pcnt_d;
    logic [11:0] ncnt_q, ncnt_d;
    logic        err_phy_q, err_phy_d;
    logic        phy_dv_q, phy_dv_d;
    logic [3:0]  phy_data_q, phy_data_d;
    logic        rx_end_q, rx_end_d;
    logic        st_phy_q, st_phy_d;
    logic        st_align_q, st_align_d;
    logic        st_long_q, st_long_d;

    always_ff @(posedge phy_rx_clk) begin
        if (phy_rx_rst) begin
            dv_q       <= 1'b0;
            er_q       <= 1'b0;
            d_q        <= 4'h0;
            state_q    <= ST_IDLE;
            pcnt_q     <= 4'h0;
            ncnt_q     <= 12'h000;
            err_phy_q  <= 1'b0;
            phy_dv_q   <= 1'b0;
            phy_data_q <= 4'h0;
            rx_end_q   <= 1'b0;
            st_phy_q   <= 1'b0;
            st_align_q <= 1'b0;
            st_long_q  <= 1'b0;
        end else begin
            dv_q       <= rx.mii_rx_dv;
            er_q       <= rx.mii_rx_er;
            d_q        <= rx.mii_rx_data;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            ncnt_q     <= ncnt_d;
            err_phy_q  <= err_phy_d;
            phy_dv_q   <= phy_dv_d;
            phy_data_q <= phy_data_d;
            rx_end_q   <= rx_end_d;
            st_phy_q   <= st_phy_d;
            st_align_q <= st_align_d;
            st_long_q  <= st_long_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        ncnt_d     = ncnt_q;
        err_phy_d  = err_phy_q;
        phy_dv_d   = 1'b0;
        phy_data_d = 4'h0;
        rx_end_d   = 1'b0;
        st_phy_d   = 1'b0;
        st_align_d = 1'b0;
        st_long_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dv_q) begin
                    if (d_q == NIB_PRE) begin
                        state_d = ST_PREAMBLE;
                        pcnt_d  = 4'd1;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end else if (d_q == NIB_PRE) begin
                    pcnt_d = (pcnt_q == 4'hF) ? 4'hF : pcnt_q + 4'd1;
                end else if ((d_q == NIB_SFD) && (pcnt_q >= PRE_MIN)) begin
                    state_d   = ST_PAYLOAD;
                    ncnt_d    = 12'h000;
                    err_phy_d = 1'b0;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            ST_PAYLOAD: begin
                if (!dv_q) begin
                    state_d    = ST_IDLE;
                    rx_end_d   = 1'b1;
                    st_phy_d   = err_phy_q;
                    st_align_d = ncnt_q[0];
                end else if (ncnt_q == NCNT_MAX) begin
                    // Oversize: close the frame now and swallow the rest of it.
                    state_d    = ST_DISCARD;
                    rx_end_d   = 1'b1;
                    st_phy_d   = err_phy_q;
                    st_align_d = ncnt_q[0];
                    st_long_d  = 1'b1;
                end else begin
                    phy_dv_d   = 1'b1;
                    phy_data_d = d_q;
                    ncnt_d     = ncnt_q + 12'd1;
                    err_phy_d  = err_phy_q | er_q;
                end
            end
            ST_DISCARD: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx.phy_dv       = phy_dv_q;
    assign rx.phy_rx_data  = phy_data_q;
    assign rx.rx_end       = rx_end_q;
    assign rx.rx_err_phy   = st_phy_q;
    assign rx.rx_err_align = st_align_q;
    assign rx.rx_err_long  = st_long_q;

`ifdef MINIMAC2_RX_CRC_EN
    logic        w_crc_clr;
    logic [31:0] w_crc;
    logic        crc_ok_q, crc_ok_d;

    assign w_crc_clr = (state_q == ST_PREAMBLE) && (state_d == ST_PAYLOAD);

    minimac2_crc4 u_crc (
        .clk    (phy_rx_clk),
        .rst    (phy_rx_rst),
        .clr_i  (w_crc_clr),
        .en_i   (phy_dv_d),
        .data_i (d_q),
        .crc_o  (w_crc)
    );

    assign crc_ok_d = rx_end_d && !st_long_d && (w_crc == MINIMAC2_CRC_RESIDUE);

    always_ff @(posedge phy_rx_clk) begin
        if (phy_rx_rst) begin
            crc_ok_q <= 1'b0;
        end else begin
            crc_ok_q <= crc_ok_d;
        end
    end

    assign rx.rx_crc_ok = crc_ok_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_minimac2_rx_sfd.sv
// ============================================================================
// tb_minimac2_rx_sfd : directed self-checking bench for the MII SFD front end
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_minimac2_rx_sfd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    minimac2_rx_sfd_if rx ();

    minimac2_rx_sfd #(
        .MIN_PREAMBLE (4),
        .MAX_NIBBLES  (3072)
    ) dut (
        .phy_rx_clk (clk),
        .phy_rx_rst (rst),
        .rx         (rx)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    int         dv_cnt = 0, end_cnt = 0, rise_cnt = 0, both_cnt = 0, stray_cnt = 0;
    int         rise_cyc = 0;
    logic       prev_dv = 1'b0;
    logic       l_phy = 1'b0, l_align = 1'b0, l_long = 1'b0;
    logic       l_crc = 1'b0;
    logic [3:0] cap[$];
    logic [3:0] pl[0:3199];
    int         t_first = 0;

    always @(negedge clk) begin
        if (rx.phy_dv === 1'b1) begin
            cap.push_back(rx.phy_rx_data);
            dv_cnt++;
            if (!prev_dv) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
        end
        if (rx.rx_end === 1'b1) begin
            end_cnt++;
            l_phy   = rx.rx_err_phy;
            l_align = rx.rx_err_align;
            l_long  = rx.rx_err_long;
`ifdef MINIMAC2_RX_CRC_EN
            l_crc   = rx.rx_crc_ok;
`endif
            if (rx.phy_dv === 1'b1) both_cnt++;
        end else if (rx.rx_err_phy !== 1'b0 || rx.rx_err_align !== 1'b0 || rx.rx_err_long !== 1'b0) begin
            stray_cnt++;
        end
        prev_dv = (rx.phy_dv === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [3:0] d);
        @(negedge clk);
        rx.mii_rx_dv   = dv;
        rx.mii_rx_er   = er;
        rx.mii_rx_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0);
    endtask

    task automatic send_frame(input int npre, input int npay, input int er_idx, input bit er_pre);
        for (int i = 0; i < npre; i++) drive(1'b1, er_pre && (i == 1), 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < npay; i++) begin
            drive(1'b1, i == er_idx, pl[i]);
            if (i == 0) t_first = cyc;
        end
        drive(1'b0, 1'b0, 4'h0);
    endtask

    function automatic int data_mismatches(input int start, input int n);
        int m = 0;
        if (cap.size() < start + n) return n;
        for (int i = 0; i < n; i++) if (cap[start+i] !== pl[i]) m++;
        return m;
    endfunction

    int s_dv, s_end, s_rise, s_cap;

    task automatic snap();
        s_dv = dv_cnt; s_end = end_cnt; s_rise = rise_cnt; s_cap = cap.size();
    endtask

`ifdef MINIMAC2_RX_CRC_EN
    logic [7:0] fb[0:63];
    task automatic build_crc_frame();
        logic [31:0] c;
        logic        f;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < 60; k++) begin
            fb[k] = 8'((k * 13) + 1);
            for (int b = 0; b < 8; b++) begin
                f = c[0] ^ fb[k][b];
                c = c >> 1;
                if (f) c = c ^ 32'hEDB88320;
            end
        end
        c = ~c;
        fb[60] = c[7:0]; fb[61] = c[15:8]; fb[62] = c[23:16]; fb[63] = c[31:24];
        for (int k = 0; k < 64; k++) begin
            pl[2*k]   = fb[k][3:0];
            pl[2*k+1] = fb[k][7:4];
        end
    endtask
`endif

    initial begin
        rx.mii_rx_dv = 1'b0; rx.mii_rx_er = 1'b0; rx.mii_rx_data = 4'h0;
        for (int i = 0; i < 3200; i++) pl[i] = 4'((i * 7) + 3);

        // Reset values
        idle(3);
        chk("rst_phy_dv",   rx.phy_dv, 0);
        chk("rst_data",     rx.phy_rx_data, 0);
        chk("rst_end",      rx.rx_end, 0);
        chk("rst_err_phy",  rx.rx_err_phy, 0);
        chk("rst_err_algn", rx.rx_err_align, 0);
        chk("rst_err_long", rx.rx_err_long, 0);
`ifdef MINIMAC2_RX_CRC_EN
        chk("rst_crc_ok",   rx.rx_crc_ok, 0);
`endif
        rst = 1'b0;
        idle(2);

        // 15 x 5, SFD, 128 payload nibbles
        snap();
        send_frame(15, 128, -1, 1'b0);
        idle(4);
        chk("f128_dv_cnt",  dv_cnt - s_dv, 128);
        chk("f128_latency", rise_cyc - t_first, 2);
        chk("f128_data",    data_mismatches(s_cap, 128), 0);
        chk("f128_end",     end_cnt - s_end, 1);
        chk("f128_flags",   {l_phy, l_align, l_long}, 3'b000);

        // Short preamble rejected
        snap();
        send_frame(3, 20, -1, 1'b0);
        idle(4);
        chk("short_pre_dv",  dv_cnt - s_dv, 0);
        chk("short_pre_end", end_cnt - s_end, 0);

        // Exactly MIN_PREAMBLE accepted
        snap();
        send_frame(4, 10, -1, 1'b0);
        idle(4);
        chk("min_pre_dv",  dv_cnt - s_dv, 10);
        chk("min_pre_end", end_cnt - s_end, 1);

        // Back-to-back frames with one dv-low cycle between them
        snap();
        send_frame(7, 8, -1, 1'b0);
        send_frame(7, 10, -1, 1'b0);
        idle(4);
        chk("b2b_dv",   dv_cnt - s_dv, 18);
        chk("b2b_end",  end_cnt - s_end, 2);
        chk("b2b_rise", rise_cnt - s_rise, 2);

        // Oversize truncation
        snap();
        send_frame(7, 3100, -1, 1'b0);
        idle(4);
        chk("long_dv",    dv_cnt - s_dv, 3072);
        chk("long_rise",  rise_cnt - s_rise, 1);
        chk("long_end",   end_cnt - s_end, 1);
        chk("long_flags", {l_phy, l_align, l_long}, 3'b001);
        chk("long_data",  data_mismatches(s_cap, 3072), 0);

        // Odd length with receive error on payload nibble 10
        snap();
        send_frame(7, 65, 10, 1'b0);
        idle(4);
        chk("odd_dv",    dv_cnt - s_dv, 65);
        chk("odd_end",   end_cnt - s_end, 1);
        chk("odd_flags", {l_phy, l_align, l_long}, 3'b110);

        // Error during preamble only is ignored
        snap();
        send_frame(7, 64, -1, 1'b1);
        idle(4);
        chk("pre_er_end",   end_cnt - s_end, 1);
        chk("pre_er_flags", {l_phy, l_align, l_long}, 3'b000);

        // Reset pulse at payload nibble 40 of an all-0xA payload
        snap();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0, 4'hA);
            rst = (i == 40);
            if (i == 41) begin
                chk("mid_rst_dv",   rx.phy_dv, 0);
                chk("mid_rst_data", rx.phy_rx_data, 0);
                chk("mid_rst_end",  rx.rx_end, 0);
            end
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0);
        idle(4);
        chk("mid_rst_no_end", end_cnt - s_end, 0);
        chk("mid_rst_rise",   rise_cnt - s_rise, 1);

        snap();
        send_frame(7, 32, -1, 1'b0);
        idle(4);
        chk("post_rst_dv",   dv_cnt - s_dv, 32);
        chk("post_rst_data", data_mismatches(s_cap, 32), 0);
        chk("post_rst_end",  end_cnt - s_end, 1);

`ifdef MINIMAC2_RX_CRC_EN
        build_crc_frame();
        snap();
        send_frame(7, 128, -1, 1'b0);
        idle(4);
        chk("crc_good_end", end_cnt - s_end, 1);
        chk("crc_good_ok",  l_crc, 1);
        pl[21] = pl[21] ^ 4'h4;
        snap();
        send_frame(7, 128, -1, 1'b0);
        idle(4);
        chk("crc_bad_end", end_cnt - s_end, 1);
        chk("crc_bad_ok",  l_crc, 0);
`endif

        chk("end_with_dv_hi", both_cnt, 0);
        chk("stray_flags",    stray_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
